// File: rtl/cflog_writer.sv
// cflog_writer: front-end of the control-flow log.
// Buffers branch events in a small FIFO and writes them one per cycle into the
// log memory. It also owns the log pointer: Spec-CFA rewinds, log-full
// detection and the flush request/acknowledge handshake.
module cflog_writer #(
    parameter logic [15:0] CFLOW_LOGS_SIZE = 16'h80,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        evt_valid,
    input  logic [15:0] evt_src,
    input  logic [15:0] evt_dest,
    input  logic        spec_rewind,
    input  logic [15:0] spec_ptr,
    input  logic        flush_ack,
    output logic [15:0] cflow_src,
    output logic [15:0] cflow_dest,
    output logic        cflow_hw_wen,
    output logic [15:0] cflow_logs_ptr_din,
    output logic [15:0] log_ptr,
    output logic        flush_req,
    output logic        cpu_stall,
    output logic        evt_overflow,
    output logic        rewind_err
);

    // Index width for the FIFO storage; the count needs one extra bit so that
    // "full" (count == FIFO_DEPTH) is representable.
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_C = CW'(FIFO_DEPTH - 1);

    typedef enum logic {
        LOG  = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state_q;

    logic [15:0]   srcMem_q  [FIFO_DEPTH];
    logic [15:0]   destMem_q [FIFO_DEPTH];
    logic [AW-1:0] wrIdx_q;
    logic [AW-1:0] rdIdx_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic [15:0]   logPtr_q;
    logic [15:0]   src_q;
    logic [15:0]   dest_q;
    logic [15:0]   ptrDin_q;
    logic          wen_q;
    logic          flushReq_q;
    logic          overflow_q;
    logic          rewindErr_q;

    logic          pushEn;
    logic          popEn;
    logic          rewindOk;
    logic [15:0]   ptrNext;

    // Decide this cycle's push, pop and rewind legality. A legal rewind steals
    // the pop slot so the rewound pointer is never raced by a write.
    always_comb begin
        pushEn   = evt_valid && (count_q < DEPTH_C);
        rewindOk = spec_rewind && !spec_ptr[0] && (spec_ptr <= logPtr_q);
        popEn    = (state_q == LOG) && !rewindOk && (count_q != '0);
        ptrNext  = logPtr_q + 16'd2;
        count_d  = count_q;
        if (pushEn && !popEn) begin
            count_d = count_q + 1'b1;
        end else if (!pushEn && popEn) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO bookkeeping: read/write indices and occupancy; reset empties it.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            wrIdx_q <= '0;
            rdIdx_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) begin
                wrIdx_q <= wrIdx_q + 1'b1;
            end
            if (popEn) begin
                rdIdx_q <= rdIdx_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // FIFO payload storage; stale contents are harmless once the indices reset.
    always_ff @(posedge mclk) begin
        if (pushEn) begin
            srcMem_q[wrIdx_q]  <= evt_src;
            destMem_q[wrIdx_q] <= evt_dest;
        end
    end

    // Log FSM: pops entries into the registered write port, moves the pointer,
    // and handles rewinds, log-full and the flush handshake.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q     <= LOG;
            logPtr_q    <= '0;
            src_q       <= '0;
            dest_q      <= '0;
            ptrDin_q    <= '0;
            wen_q       <= 1'b0;
            flushReq_q  <= 1'b0;
            overflow_q  <= 1'b0;
            rewindErr_q <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            if (evt_valid && !pushEn) begin
                overflow_q <= 1'b1;
            end
            if (spec_rewind && !rewindOk) begin
                rewindErr_q <= 1'b1;
            end
            case (state_q)
                LOG: begin
                    if (rewindOk) begin
                        logPtr_q <= spec_ptr;
                    end else if (popEn) begin
                        src_q    <= srcMem_q[rdIdx_q];
                        dest_q   <= destMem_q[rdIdx_q];
                        ptrDin_q <= ptrNext;
                        wen_q    <= 1'b1;
                        logPtr_q <= ptrNext;
                        if (ptrNext == CFLOW_LOGS_SIZE) begin
                            state_q    <= FULL;
                            flushReq_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (rewindOk) begin
                        logPtr_q <= spec_ptr;
                        if (spec_ptr < CFLOW_LOGS_SIZE) begin
                            state_q    <= LOG;
                            flushReq_q <= 1'b0;
                        end
                    end else if (flush_ack) begin
                        logPtr_q   <= '0;
                        flushReq_q <= 1'b0;
                        state_q    <= LOG;
                    end
                end
                default: begin
                    state_q <= LOG;
                end
            endcase
        end
    end

    assign cflow_src          = src_q;
    assign cflow_dest         = dest_q;
    assign cflow_hw_wen       = wen_q;
    assign cflow_logs_ptr_din = ptrDin_q;
    assign log_ptr            = logPtr_q;
    assign flush_req          = flushReq_q;
    assign evt_overflow       = overflow_q;
    assign rewind_err         = rewindErr_q;
    assign cpu_stall          = (count_q >= STALL_C) || (state_q == FULL);

endmodule
